frame_text_display: RTL and testbench
=====================================

Name: frame_text_display

Overview:
- Downstream consumer of the cycle printer's screen-write stream (frame_char/frame_x/frame_y/frame_we).
- Holds a 40x30 character buffer and renders it as 640x480@60 VGA text, using 16x16-pixel cells (8x8 glyphs scaled 2x).
- Owns buffer clearing, so the printer only ever issues single-cell writes.

Parameters:
- COLS, 40, character columns.
- ROWS, 30, character rows.
- BLANK_CHAR, 10, code written by clear; renders as background.
- ARROW_CHAR, 37, arrow glyph code.

Ports:
- clk  in  1  50 MHz system clock.
- reset_n  in  1  synchronous, active-low reset.
- frame_char  in  6  character code to write.
- frame_x  in  6  target column.
- frame_y  in  6  target row.
- frame_we  in  1  write strobe, one cell per cycle.
- frame_clear  in  1  pulse: blank the whole buffer.
- clear_busy  out  1  high while clear is in progress.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- VGA_HS, VGA_VS  out  1  active-low syncs.
- VGA_BLANK_n  out  1  low outside the visible area.
- VGA_SYNC_n  out  1  tied to 0.
- VGA_CLK  out  1  25 MHz pixel clock (clk/2).

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - hcount=vcount=0, pix_tick=0, VGA_CLK=0.
  - VGA_HS=VGA_VS=1, VGA_BLANK_n=0, RGB=0.
  - Pipeline registers cleared.
  - FSM forced to CLEAR with clr_addr=0, clear_busy=1.
  - Reset asserted mid-clear restarts the clear from address 0.
- Buffer:
  - 1200 x 6-bit dual-port RAM; address = y*COLS+x, computed as (y<<5)+(y<<3)+x.
  - Port A: writes. Port B: display reads.
- Write rules:
  - In IDLE, frame_we=1 with x<COLS and y<ROWS writes frame_char at that posedge.
  - Out-of-range coordinates are dropped; there is no wrap or alias.
  - Writes are posted with no back-pressure.
- FSM:
  - IDLE: on frame_clear=1, go to CLEAR with clr_addr=0. A frame_we in the same cycle is dropped; clear wins.
  - CLEAR: write BLANK_CHAR at clr_addr, one per cycle. clr_addr=1199 returns to IDLE next cycle.
  - Cycle count: clear_busy is high exactly 1200 cycles and falls on the cycle the FSM re-enters IDLE.
  - While in CLEAR: frame_we is ignored; a frame_clear pulse is ignored and does not restart the clear.
- Timing:
  - pix_tick toggles every clk; counters advance when pix_tick=1.
  - H: 640 visible, 16 front porch, 96 sync, 48 back porch; total 800. hcount wraps 799 to 0.
  - V: 480 visible, 10 front porch, 2 sync, 33 back porch; total 525. vcount increments at hcount wrap and wraps 524 to 0.
  - VGA_CLK = registered pix_tick.
- Pixel pipeline (2 pixel ticks):
  - Stage 1: read buffer at (vcount>>4)*40+(hcount>>4).
  - Stage 2: glyph ROM address = {char, vcount[3:1]}, bit select = hcount[3:1]. The vcount and hcount bits are delayed to stay aligned with their data.
  - HS, VS and visible are delayed 2 ticks to match.
- Sync and colour:
  - HS raw is low for hcount 656..751; VS raw is low for vcount 490..491.
  - Visible = hcount<640 && vcount<480.
  - Glyph bit 1 gives RGB=FF/FF/FF; bit 0 gives 00/00/00. Outside visible, RGB is 0.
- Glyph table:
  - Codes 0-9 are digits; 11-36 are A-Z; 37 is '>'.
  - Code 10 and codes 38-63 render as all background.
- Display reads continue during CLEAR and show partially cleared content; this is acceptable.

Test Plan:
- Reset, hold 2 cycles, release: clear_busy high for exactly 1200 clks, then 0. One full frame: every visible pixel is 0 and VGA_BLANK_n toggles per visible region.
- After clear, write char 3 at (0,0) and 37 at (39,29): frame pixels (0..15,0..15) match the '3' glyph scaled 2x, pixels (624..639,464..479) match '>', all others black.
- Write x=40,y=0 and x=0,y=30 with char 5: no pixel change anywhere, (0,0) still shows '3'.
- Timing:
  - HS falling edges are 1600 clks apart, with a low width of 192 clks.
  - VS is low for exactly 2 lines (3200 clks), and its falling edges are 840000 clks apart.
  - Syncs and RGB are aligned with the 2-tick pipeline.
- Simultaneous and during-clear events:
  - frame_clear and frame_we (char 1 at (2,2)) in the same cycle: the write is dropped and clear_busy rises next cycle.
  - A write issued at clear cycle 600 has no effect; the cell reads blank afterward.
- Assert reset_n=0 at clear cycle 700, release: clear restarts with clear_busy high for a full 1200 clks; syncs resume from hcount=vcount=0.

Source files
------------

// File: rtl/frame_text_display.sv
// frame_text_display: 40x30 character buffer written one cell per cycle, rendered as 640x480@60 VGA text.
// Owns whole-buffer clearing; display path is two pixel ticks from counters to VGA pins.
module frame_text_display #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [5:0] BLANK_CHAR = 6'd10,
    parameter logic [5:0] ARROW_CHAR = 6'd37
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] frame_char,
    input  logic [5:0] frame_x,
    input  logic [5:0] frame_y,
    input  logic       frame_we,
    input  logic       frame_clear,
    output logic       clear_busy,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_n,
    output logic       VGA_SYNC_n,
    output logic       VGA_CLK
);
    localparam int          CELLS     = COLS * ROWS;
    localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
    // 640 visible + 16 front + 96 sync + 48 back; 480 visible + 10 front + 2 sync + 33 back
    localparam logic [9:0] H_VIS = 10'd640, H_SYNC_ON = 10'd656, H_SYNC_OFF = 10'd752, H_LAST = 10'd799;
    localparam logic [9:0] V_VIS = 10'd480, V_SYNC_ON = 10'd490, V_SYNC_OFF = 10'd492, V_LAST = 10'd524;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    function automatic logic [63:0] glyph(input logic [5:0] code);
        logic [63:0] g;
        g = '0;
        if (code == ARROW_CHAR) begin
            g = 64'h6030180C18306000;
        end else begin
            case (code)
                6'd0:  g = 64'h3C666E7666663C00;
                6'd1:  g = 64'h1838181818187E00;
                6'd2:  g = 64'h3C66060C30607E00;
                6'd3:  g = 64'h3C66061C06663C00;
                6'd4:  g = 64'h0C1C3C6C7E0C0C00;
                6'd5:  g = 64'h7E607C0606663C00;
                6'd6:  g = 64'h3C607C6666663C00;
                6'd7:  g = 64'h7E060C1830303000;
                6'd8:  g = 64'h3C66663C66663C00;
                6'd9:  g = 64'h3C66663E060C3800;
                6'd11: g = 64'h183C66667E666600;
                6'd12: g = 64'h7C66667C66667C00;
                6'd13: g = 64'h3C66606060663C00;
                6'd14: g = 64'h786C6666666C7800;
                6'd15: g = 64'h7E60607C60607E00;
                6'd16: g = 64'h7E60607C60606000;
                6'd17: g = 64'h3C66606E66663C00;
                6'd18: g = 64'h6666667E66666600;
                6'd19: g = 64'h3C18181818183C00;
                6'd20: g = 64'h1E0C0C0C0C6C3800;
                6'd21: g = 64'h666C7870786C6600;
                6'd22: g = 64'h6060606060607E00;
                6'd23: g = 64'h63777F6B63636300;
                6'd24: g = 64'h66767E7E6E666600;
                6'd25: g = 64'h3C66666666663C00;
                6'd26: g = 64'h7C66667C60606000;
                6'd27: g = 64'h3C666666663C0E00;
                6'd28: g = 64'h7C66667C786C6600;
                6'd29: g = 64'h3C66603C06663C00;
                6'd30: g = 64'h7E18181818181800;
                6'd31: g = 64'h6666666666663C00;
                6'd32: g = 64'h66666666663C1800;
                6'd33: g = 64'h6363636B7F776300;
                6'd34: g = 64'h66663C183C666600;
                6'd35: g = 64'h6666663C18181800;
                6'd36: g = 64'h7E060C1830607E00;
                default: g = '0;
            endcase
        end
        return g;
    endfunction

    logic [5:0] char_ram [CELLS];

    state_t      state_q, state_d;
    logic [10:0] clr_addr_q, clr_addr_d;
    logic        pix_tick_q, pix_tick_d;
    logic        vga_clk_q, vga_clk_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [5:0]  char1_q, char1_d;
    logic [2:0]  hbit1_q, hbit1_d;
    logic [2:0]  vrow1_q, vrow1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic        pix_on_q, pix_on_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, vis2_q, vis2_d;

    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [5:0]  ram_wdat;
    logic [10:0] wr_addr, rd_addr;
    logic        wr_in_range, vis_raw, hs_raw, vs_raw;
    logic [63:0] glyph_bits;
    logic [7:0]  glyph_row;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        wr_in_range = (frame_x < 6'(COLS)) && (frame_y < 6'(ROWS));
        wr_addr     = (11'(frame_y) << 5) + (11'(frame_y) << 3) + 11'(frame_x);
        ram_we      = 1'b0;
        ram_waddr   = wr_addr;
        ram_wdat    = frame_char;
        case (state_q)
            ST_IDLE: begin
                // A clear request takes priority over a write arriving in the same cycle
                if (frame_clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (frame_we && wr_in_range) begin
                    ram_we = 1'b1;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdat  = BLANK_CHAR;
                if (clr_addr_q == LAST_CELL) state_d = ST_IDLE;
                else                         clr_addr_d = clr_addr_q + 11'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_tick_d = ~pix_tick_q;
        vga_clk_d  = pix_tick_q;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        if (pix_tick_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        vis_raw = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        hs_raw  = !((hcount_q >= H_SYNC_ON) && (hcount_q < H_SYNC_OFF));
        vs_raw  = !((vcount_q >= V_SYNC_ON) && (vcount_q < V_SYNC_OFF));
        // Non-visible counter values would index past the buffer; their data is masked anyway
        rd_addr = vis_raw ? (11'(vcount_q[9:4]) << 5) + (11'(vcount_q[9:4]) << 3) + 11'(hcount_q[9:4])
                          : 11'd0;

        glyph_bits = glyph(char1_q);
        glyph_row  = glyph_bits[{~vrow1_q, 3'b000} +: 8];

        char1_d  = pix_tick_q ? char_ram[rd_addr] : char1_q;
        hbit1_d  = pix_tick_q ? hcount_q[3:1]     : hbit1_q;
        vrow1_d  = pix_tick_q ? vcount_q[3:1]     : vrow1_q;
        hs1_d    = pix_tick_q ? hs_raw            : hs1_q;
        vs1_d    = pix_tick_q ? vs_raw            : vs1_q;
        vis1_d   = pix_tick_q ? vis_raw           : vis1_q;
        pix_on_d = pix_tick_q ? (vis1_q && glyph_row[~hbit1_q]) : pix_on_q;
        hs2_d    = pix_tick_q ? hs1_q             : hs2_q;
        vs2_d    = pix_tick_q ? vs1_q             : vs2_q;
        vis2_d   = pix_tick_q ? vis1_q            : vis2_q;
    end

    always_ff @(posedge clk) begin
        if (ram_we) char_ram[ram_waddr] <= ram_wdat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            pix_tick_q <= 1'b0;
            vga_clk_q  <= 1'b0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            char1_q    <= '0;
            hbit1_q    <= '0;
            vrow1_q    <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vis1_q     <= 1'b0;
            pix_on_q   <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            vis2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            pix_tick_q <= pix_tick_d;
            vga_clk_q  <= vga_clk_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            char1_q    <= char1_d;
            hbit1_q    <= hbit1_d;
            vrow1_q    <= vrow1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            vis1_q     <= vis1_d;
            pix_on_q   <= pix_on_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            vis2_q     <= vis2_d;
        end
    end

    assign clear_busy  = (state_q == ST_CLEAR);
    assign VGA_R       = {8{pix_on_q}};
    assign VGA_G       = {8{pix_on_q}};
    assign VGA_B       = {8{pix_on_q}};
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_n = vis2_q;
    assign VGA_SYNC_n  = 1'b0;
    assign VGA_CLK     = vga_clk_q;

endmodule

// File: tb/tb_frame_text_display.sv
// Directed bench for frame_text_display: clear timing, cell writes rendered on screen, sync timing, clear/reset corner cases.
`timescale 1ns/1ps
module tb_frame_text_display;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] frame_char, frame_x, frame_y;
    logic       frame_we, frame_clear;
    logic       clear_busy;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK;
    logic [27:0] vga_vec;

    frame_text_display dut (
        .clk(clk), .reset_n(reset_n),
        .frame_char(frame_char), .frame_x(frame_x), .frame_y(frame_y),
        .frame_we(frame_we), .frame_clear(frame_clear), .clear_busy(clear_busy),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .VGA_SYNC_n(VGA_SYNC_n), .VGA_CLK(VGA_CLK)
    );

    always #5 clk = ~clk;
    assign vga_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK};

    int checks = 0;
    int passes = 0;
    int n;
    logic [5:0] model_mem [1200];
    logic [7:0] g_three [8] = '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00};
    logic [7:0] g_arrow [8] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h00};
    bit   scan_on;
    int   line_bad, bad_n, fall1, fall2, rise1;
    logic [27:0] bad_got, bad_exp;
    logic prev_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes = passes + 1;
        else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s did not match", tag);
        end
    endtask

    function automatic logic [7:0] tb_glyph(input logic [5:0] code, input int r);
        if (code == 6'd3)  return g_three[r];
        if (code == 6'd37) return g_arrow[r];
        return 8'h00;
    endfunction

    // Pins after the k-th clock edge since reset release; pixel k is two ticks (four edges) behind
    function automatic logic [27:0] model_out(input int k);
        int p, h, v;
        logic vis, hs, vs, on, vclk;
        logic [7:0] row;
        vclk = (k > 0) && (k % 2 == 0);
        if (k < 4) return {24'h0, 1'b1, 1'b1, 1'b0, vclk};
        p   = (k - 4) / 2;
        h   = p % 800;
        v   = (p / 800) % 525;
        vis = (h < 640) && (v < 480);
        hs  = !((h >= 656) && (h <= 751));
        vs  = !((v >= 490) && (v <= 491));
        on  = 1'b0;
        if (vis) begin
            row = tb_glyph(model_mem[(v / 16) * 40 + h / 16], (v % 16) / 2);
            on  = row[7 - (h % 16) / 2];
        end
        return {{24{on}}, hs, vs, vis, vclk};
    endfunction

    task automatic step();
        logic [27:0] exp;
        @(posedge clk);
        n++;
        @(negedge clk);
        if (scan_on) begin
            exp = model_out(n);
            if (vga_vec !== exp) begin
                if (line_bad == 0) begin
                    bad_n = n; bad_got = vga_vec; bad_exp = exp;
                end
                line_bad++;
            end
            if (prev_hs && !VGA_HS) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev_hs && VGA_HS && rise1 < 0) rise1 = n;
            prev_hs = VGA_HS;
            if (n >= 4 && (n - 4) % 1600 == 1599) begin
                check($sformatf("line %0d bad samples (first at cyc %0d pins %h want %h)",
                                ((n - 4) / 1600) % 525, bad_n, bad_got, bad_exp), 64'(line_bad), 64'd0);
                line_bad = 0;
            end
        end
    endtask

    task automatic scan_start();
        scan_on = 1'b1;
        line_bad = 0; bad_n = -1; bad_got = '0; bad_exp = '0;
        fall1 = -1; fall2 = -1; rise1 = -1;
        prev_hs = VGA_HS;
    endtask

    task automatic wr(input logic [5:0] x, input logic [5:0] y, input logic [5:0] c);
        frame_x = x; frame_y = y; frame_char = c; frame_we = 1'b1;
        step();
        frame_we = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; frame_we = 1'b0; frame_clear = 1'b0;
        frame_char = '0; frame_x = '0; frame_y = '0;
        scan_on = 1'b0; n = 0;
        for (int i = 0; i < 1200; i++) model_mem[i] = 6'd10;

        step(); step();
        check("reset pins", 64'(vga_vec), 64'h000000C);
        check("reset clear_busy", 64'(clear_busy), 64'd1);
        check("sync_n tied low", 64'(VGA_SYNC_n), 64'd0);

        reset_n = 1'b1; n = 0;
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 3000) begin step(); cnt++; end
        check("initial clear busy cycles", 64'(cnt), 64'd1200);

        wr(6'd0, 6'd0, 6'd3);    model_mem[0]    = 6'd3;
        wr(6'd39, 6'd0, 6'd37);  model_mem[39]   = 6'd37;
        wr(6'd39, 6'd29, 6'd37); model_mem[1199] = 6'd37;
        wr(6'd40, 6'd0, 6'd5);
        wr(6'd0, 6'd30, 6'd5);
        check("cell (39,29) holds arrow", 64'(dut.char_ram[1199]), 64'd37);
        check("x=40 write did not alias (0,1)", 64'(dut.char_ram[40]), 64'd10);

        while (n < 1603) step();
        scan_start();
        while (n < 28803) step();
        scan_on = 1'b0;
        check("first hs fall aligned", 64'(fall1), 64'd2916);
        check("hs period", 64'(fall2 - fall1), 64'd1600);
        check("hs low width", 64'(rise1 - fall1), 64'd192);

        check("idle before clear", 64'(clear_busy), 64'd0);
        frame_clear = 1'b1; frame_we = 1'b1; frame_char = 6'd1; frame_x = 6'd2; frame_y = 6'd2;
        step();
        frame_clear = 1'b0; frame_we = 1'b0;
        check("clear_busy rises after clear pulse", 64'(clear_busy), 64'd1);
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 3000) begin
            frame_we    = (cnt == 600);
            frame_clear = (cnt == 650);
            step();
            cnt++;
        end
        frame_we = 1'b0; frame_clear = 1'b0;
        check("clear not restarted by mid-clear pulse", 64'(cnt), 64'd1200);
        check("mid-clear write to (2,2) ignored", 64'(dut.char_ram[82]), 64'd10);
        check("cell (0,0) cleared", 64'(dut.char_ram[0]), 64'd10);
        for (int i = 0; i < 1200; i++) model_mem[i] = 6'd10;

        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        for (int i = 0; i < 700; i++) step();
        check("busy at clear cycle 700", 64'(clear_busy), 64'd1);
        reset_n = 1'b0;
        step(); step();
        check("busy during mid-clear reset", 64'(clear_busy), 64'd1);
        check("pins during mid-clear reset", 64'(vga_vec), 64'h000000C);

        reset_n = 1'b1; n = 0;
        scan_start();
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 3000) begin step(); cnt++; end
        check("restarted clear busy cycles", 64'(cnt), 64'd1200);
        while (n < 1603) step();
        scan_on = 1'b0;
        check("hs fall after reset", 64'(fall1), 64'd1316);
        check("hs rise after reset", 64'(rise1), 64'd1508);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
